// File: rtl/pll_lock_monitor.sv
// PLL lock monitor: synchronises pll_lock, sequences PLL reset and the release of
// the PLL-clocked reset tree, and counts lock losses and lock timeouts.
module pll_lock_monitor #(
    parameter int unsigned RST_PULSE     = 16,
    parameter int unsigned LOCK_TIMEOUT  = 50000,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pll_lock,
    input  logic             clr_cnt,
    output logic             pll_rst,
    output logic             sys_rst_n,
    output logic             locked,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] loss_cnt,
    output logic [CNT_W-1:0] timeout_cnt
);

    localparam int unsigned MAX_A = (RST_PULSE > LOCK_TIMEOUT) ? RST_PULSE : LOCK_TIMEOUT;
    localparam int unsigned MAX_C = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
    localparam int unsigned CYC_W = (MAX_C > 1) ? $clog2(MAX_C) : 1;

    localparam logic [CYC_W-1:0] RST_LAST    = CYC_W'(RST_PULSE - 1);
    localparam logic [CYC_W-1:0] TIMEOUT_LAST = CYC_W'(LOCK_TIMEOUT - 1);
    localparam logic [CYC_W-1:0] STABLE_LAST = CYC_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RST       = 2'b00,
        ST_WAIT_LOCK = 2'b01,
        ST_STABLE    = 2'b10,
        ST_RUN       = 2'b11
    } state_e;

    state_e           state_q, state_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic [1:0]       sync_q;
    logic             pll_rst_q, pll_rst_d;
    logic             run_q, run_d;
    logic [CNT_W-1:0] loss_q, loss_d;
    logic [CNT_W-1:0] to_q, to_d;
    logic             lock_s;
    logic             loss_inc;
    logic             to_inc;

    assign lock_s = sync_q[1];

    always_comb begin
        state_d  = state_q;
        loss_inc = 1'b0;
        to_inc   = 1'b0;
        case (state_q)
            ST_RST: begin
                if (cyc_q == RST_LAST) state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                // Lock beats a coincident timeout.
                if (lock_s) begin
                    state_d = ST_STABLE;
                end else if (cyc_q == TIMEOUT_LAST) begin
                    state_d = ST_RST;
                    to_inc  = 1'b1;
                end
            end
            ST_STABLE: begin
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                end else if (cyc_q == STABLE_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!lock_s) begin
                    state_d  = ST_WAIT_LOCK;
                    loss_inc = 1'b1;
                end
            end
            default: state_d = ST_RST;
        endcase

        // The cycle counter is never consulted in RUN, so it simply holds there.
        if (state_d != state_q) begin
            cyc_d = '0;
        end else if (state_q == ST_RUN) begin
            cyc_d = cyc_q;
        end else begin
            cyc_d = cyc_q + 1'b1;
        end

        pll_rst_d = (state_d == ST_RST);
        run_d     = (state_d == ST_RUN);

        if (clr_cnt) begin
            loss_d = '0;
            to_d   = '0;
        end else begin
            loss_d = (loss_inc && (loss_q != '1)) ? loss_q + 1'b1 : loss_q;
            to_d   = (to_inc && (to_q != '1)) ? to_q + 1'b1 : to_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_RST;
            cyc_q     <= '0;
            sync_q    <= '0;
            pll_rst_q <= 1'b1;
            run_q     <= 1'b0;
            loss_q    <= '0;
            to_q      <= '0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            sync_q    <= {sync_q[0], pll_lock};
            pll_rst_q <= pll_rst_d;
            run_q     <= run_d;
            loss_q    <= loss_d;
            to_q      <= to_d;
        end
    end

    assign state       = state_q;
    assign pll_rst     = pll_rst_q;
    assign sys_rst_n   = run_q;
    assign locked      = run_q;
    assign loss_cnt    = loss_q;
    assign timeout_cnt = to_q;

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Bench for pll_lock_monitor: directed scenarios plus random lock patterns, every
// cycle compared against a phase/elapsed-time reference model.
module tb_pll_lock_monitor;

    localparam int unsigned RP = 4;
    localparam int unsigned LT = 100;
    localparam int unsigned SC = 8;
    localparam int unsigned CW = 3;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk;
    logic          rst_n;
    logic          pll_lock;
    logic          clr_cnt;
    logic          pll_rst;
    logic          sys_rst_n;
    logic          locked;
    logic [1:0]    state;
    logic [CW-1:0] loss_cnt;
    logic [CW-1:0] timeout_cnt;

    int errs   = 0;
    int checks = 0;

    pll_lock_monitor #(
        .RST_PULSE    (RP),
        .LOCK_TIMEOUT (LT),
        .STABLE_CYCLES(SC),
        .CNT_W        (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pll_lock   (pll_lock),
        .clr_cnt    (clr_cnt),
        .pll_rst    (pll_rst),
        .sys_rst_n  (sys_rst_n),
        .locked     (locked),
        .state      (state),
        .loss_cnt   (loss_cnt),
        .timeout_cnt(timeout_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: phase number (output encoding), time spent in the phase,
    // lock history for the two-edge synchroniser delay, and event tallies.
    int m_phase;
    int m_elapsed;
    int m_loss;
    int m_to;
    bit m_hist[$];

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input bit r, input bit l, input bit c);
        bit seen;
        int nxt;
        bit lost;
        bit timed_out;
        if (!r) begin
            m_phase   = 0;
            m_elapsed = 0;
            m_loss    = 0;
            m_to      = 0;
            m_hist    = '{1'b0, 1'b0};
            return;
        end
        seen = m_hist.pop_front();
        m_hist.push_back(l);
        nxt       = m_phase;
        lost      = 1'b0;
        timed_out = 1'b0;
        if (m_phase == 0 && m_elapsed + 1 == RP) nxt = 1;
        else if (m_phase == 1 && seen) nxt = 2;
        else if (m_phase == 1 && m_elapsed + 1 == LT) begin nxt = 0; timed_out = 1'b1; end
        else if (m_phase == 2 && !seen) nxt = 1;
        else if (m_phase == 2 && m_elapsed + 1 == SC) nxt = 3;
        else if (m_phase == 3 && !seen) begin nxt = 1; lost = 1'b1; end
        m_elapsed = (nxt != m_phase) ? 0 : m_elapsed + 1;
        m_phase   = nxt;
        if (c) begin
            m_loss = 0;
            m_to   = 0;
        end else begin
            if (lost) m_loss = (m_loss < CMAX) ? m_loss + 1 : CMAX;
            if (timed_out) m_to = (m_to < CMAX) ? m_to + 1 : CMAX;
        end
    endtask

    task automatic step(input bit r, input bit l, input bit c);
        rst_n    = r;
        pll_lock = l;
        clr_cnt  = c;
        @(posedge clk);
        model_edge(r, l, c);
        #1;
        check_val("state", int'(state), m_phase);
        check_val("pll_rst", int'(pll_rst), (m_phase == 0) ? 1 : 0);
        check_val("sys_rst_n", int'(sys_rst_n), (m_phase == 3) ? 1 : 0);
        check_val("locked", int'(locked), (m_phase == 3) ? 1 : 0);
        check_val("loss_cnt", int'(loss_cnt), m_loss);
        check_val("timeout_cnt", int'(timeout_cnt), m_to);
    endtask

    task automatic hold(input bit l, input int n);
        for (int i = 0; i < n; i++) step(1'b1, l, 1'b0);
    endtask

    initial begin
        bit lvl;
        int run;
        m_phase   = 0;
        m_elapsed = 0;
        m_loss    = 0;
        m_to      = 0;
        m_hist    = '{1'b0, 1'b0};

        // Reset, then lock present from the start
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
        hold(1'b1, 30);
        check_val("reach_run", int'(state), 3);

        // Loss in RUN, then relock back to RUN
        hold(1'b0, 1);
        hold(1'b1, 20);
        check_val("loss_once", int'(loss_cnt), 1);

        // Clear coinciding with a loss edge (loss seen two edges after the drop)
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        check_val("clr_beats_loss", int'(loss_cnt), 0);
        hold(1'b1, 20);

        // Glitch while in STABLE
        hold(1'b0, 3);
        hold(1'b1, 8);
        hold(1'b0, 3);
        hold(1'b1, 20);

        // No lock: repeated timeouts saturate
        hold(1'b0, 900);
        check_val("timeout_sat", int'(timeout_cnt), CMAX);

        // Reset pulse while in RUN
        hold(1'b1, 30);
        step(1'b0, 1'b1, 1'b0);
        check_val("rst_in_run", int'(state), 0);
        hold(1'b1, 30);

        // Random lock patterns with occasional clears and resets
        lvl = 1'b1;
        for (int seg = 0; seg < 250; seg++) begin
            run = ($urandom_range(0, 7) == 0) ? int'($urandom_range(60, 150))
                                              : int'($urandom_range(1, 25));
            for (int i = 0; i < run; i++) begin
                step(($urandom_range(0, 299) != 0), lvl, ($urandom_range(0, 19) == 0));
            end
            lvl = ~lvl;
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
